// File: rtl/sdr_wr_burst_buffer_pkg.sv
// Shared SDRAM write-path definitions: data width, idle byte mask and burst FSM encoding.
package sdr_wr_burst_buffer_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned DmW   = 2;
  localparam int unsigned EntryW = DataW + DmW;

  // All bytes masked: the SDRAM ignores the data lines outside a burst.
  localparam logic [DmW-1:0] DmIdle = 2'b11;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } burst_state_e;

endpackage

// File: rtl/sdr_wr_fifo.sv
// Synchronous FIFO holding {DM, DATA} entries; pointers wrap modulo DEPTH.
module sdr_wr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     PUSH,
  input  logic [WIDTH-1:0]         PUSH_DATA,
  input  logic                     POP,
  output logic [WIDTH-1:0]         POP_DATA,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // A push while full is dropped; a pop on empty is ignored.
  assign push_ok = PUSH && (count_q != DepthC);
  assign pop_ok  = POP && (count_q != '0);

  // Storage needs no reset; only written entries are ever read.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= PUSH_DATA;
    end
  end

  // Occupancy next state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign POP_DATA = mem_q[rd_ptr_q];
  assign FULL     = (count_q == DepthC);
  assign COUNT    = count_q;

endmodule

// File: rtl/sdr_wr_burst_buffer.sv
// Host write buffer that streams fixed-length bursts to the SDRAM data path on grant.
module sdr_wr_burst_buffer
  import sdr_wr_burst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   WR_EN,
  input  logic [DataW-1:0]       WR_DATA,
  input  logic [DmW-1:0]         WR_DM,
  output logic                   WR_FULL,
  output logic [$clog2(DEPTH):0] WR_COUNT,
  output logic                   BURST_REQ,
  input  logic                   BURST_START,
  output logic                   BURST_ACTIVE,
  output logic [DataW-1:0]       DATAIN,
  output logic [DmW-1:0]         DM
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] BurstLenC = CW'(BURST_LEN);
  localparam logic [BW-1:0] LastBeat  = BW'(BURST_LEN - 1);

  burst_state_e     state_q, state_d;
  logic [BW-1:0]    beat_q;
  logic             pop;
  logic             burst_req;
  logic [EntryW-1:0] pop_data;
  logic [CW-1:0]    count;
  logic [DataW-1:0] datain_q;
  logic [DmW-1:0]   dm_q;
  logic             active_q;

  sdr_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PUSH      (WR_EN),
    .PUSH_DATA ({WR_DM, WR_DATA}),
    .POP       (pop),
    .POP_DATA  (pop_data),
    .FULL      (WR_FULL),
    .COUNT     (count)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grants only count in IDLE with a pending request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (BURST_START && burst_req) state_d = StBurst;
      StBurst: if (beat_q == LastBeat)       state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: request while idle with a full burst buffered, pop every BURST cycle.
  always_comb begin
    burst_req = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StIdle:  burst_req = (count >= BurstLenC);
      StBurst: pop       = 1'b1;
      default: ;
    endcase
  end

  // Beat counter within the current burst.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      beat_q <= '0;
    end else if (state_q == StBurst && beat_q != LastBeat) begin
      beat_q <= beat_q + 1'b1;
    end else begin
      beat_q <= '0;
    end
  end

  // Output stage: popped word appears one cycle after its pop, idle pattern otherwise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      datain_q <= '0;
      dm_q     <= DmIdle;
      active_q <= 1'b0;
    end else if (pop) begin
      datain_q <= pop_data[DataW-1:0];
      dm_q     <= pop_data[EntryW-1:DataW];
      active_q <= 1'b1;
    end else begin
      datain_q <= '0;
      dm_q     <= DmIdle;
      active_q <= 1'b0;
    end
  end

  assign WR_COUNT     = count;
  assign BURST_REQ    = burst_req;
  assign BURST_ACTIVE = active_q;
  assign DATAIN       = datain_q;
  assign DM           = dm_q;

endmodule

// File: tb/tb_sdr_wr_burst_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_sdr_wr_burst_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BL    = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic [1:0]  WR_DM = '0;
  logic        WR_FULL;
  logic [4:0]  WR_COUNT;
  logic        BURST_REQ;
  logic        BURST_START = 1'b0;
  logic        BURST_ACTIVE;
  logic [15:0] DATAIN;
  logic [1:0]  DM;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered words, remaining pops of the current burst, output stage.
  logic [17:0] mq[$];
  int          m_busy = 0;
  bit          m_valid = 0;
  logic [17:0] m_word = '0;

  sdr_wr_burst_buffer #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .WR_EN        (WR_EN),
    .WR_DATA      (WR_DATA),
    .WR_DM        (WR_DM),
    .WR_FULL      (WR_FULL),
    .WR_COUNT     (WR_COUNT),
    .BURST_REQ    (BURST_REQ),
    .BURST_START  (BURST_START),
    .BURST_ACTIVE (BURST_ACTIVE),
    .DATAIN       (DATAIN),
    .DM           (DM)
  );

  always #5 CLK = ~CLK;

  task automatic model_clear();
    mq.delete();
    m_busy  = 0;
    m_valid = 0;
    m_word  = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic cyc(input bit we, input logic [15:0] d, input logic [1:0] dm, input bit bs);
    int cnt;
    bit req;
    WR_EN = we; WR_DATA = d; WR_DM = dm; BURST_START = bs;
    @(posedge CLK);
    cnt = mq.size();
    req = (m_busy == 0) && (cnt >= BL);
    if (m_busy > 0) begin
      m_word  = mq.pop_front();
      m_valid = 1;
      m_busy--;
    end else begin
      m_valid = 0;
      if (bs && req) m_busy = BL;
    end
    if (we && cnt < DEPTH) mq.push_back({dm, d});
    #1;
    WR_EN = 1'b0; BURST_START = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #12;
    n_checks += 6;
    if (WR_COUNT !== 5'd0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", WR_COUNT); end
    if (WR_FULL !== 1'b0)    begin n_fail++; $display("FAIL reset_full: got %b want 0", WR_FULL); end
    if (BURST_REQ !== 1'b0)  begin n_fail++; $display("FAIL reset_req: got %b want 0", BURST_REQ); end
    if (BURST_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", BURST_ACTIVE); end
    if (DM !== 2'b11)        begin n_fail++; $display("FAIL reset_dm: got %b want 11", DM); end
    if (DATAIN !== 16'h0)    begin n_fail++; $display("FAIL reset_datain: got %h want 0000", DATAIN); end
    model_clear();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) cyc(1, 16'h1000 + 16'(i), 2'b00, 0);
    n_checks += 2;
    if (WR_COUNT !== 5'd8) begin n_fail++; $display("FAIL single_count: got %0d want 8", WR_COUNT); end
    if (BURST_REQ !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", BURST_REQ); end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (BURST_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL single_latency: active %b want 0", BURST_ACTIVE); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      exp = 16'h1000 + 16'(i);
      n_checks++;
      if (DATAIN !== exp || DM !== 2'b00 || BURST_ACTIVE !== 1'b1) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h/%b/%b want %h/00/1", i, DATAIN, DM, BURST_ACTIVE, exp);
      end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (DM !== 2'b11 || BURST_ACTIVE !== 1'b0 || WR_COUNT !== 5'd0 || DATAIN !== 16'h0) begin
      n_fail++;
      $display("FAIL single_end: dm %b active %b count %0d data %h want 11/0/0/0000",
               DM, BURST_ACTIVE, WR_COUNT, DATAIN);
    end
  endtask

  task automatic test_full();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) cyc(1, 16'h2000 + 16'(i), 2'b00, 0);
    n_checks++;
    if (WR_FULL !== 1'b1 || WR_COUNT !== 5'd16) begin
      n_fail++; $display("FAIL full_flag: full %b count %0d want 1/16", WR_FULL, WR_COUNT);
    end
    cyc(1, 16'hDEAD, 2'b01, 0);
    cyc(1, 16'hBEEF, 2'b01, 0);
    n_checks++;
    if (WR_FULL !== 1'b1 || WR_COUNT !== 5'd16) begin
      n_fail++; $display("FAIL full_drop: full %b count %0d want 1/16", WR_FULL, WR_COUNT);
    end
    for (int b = 0; b < 2; b++) begin
      n_checks++;
      if (BURST_REQ !== 1'b1) begin n_fail++; $display("FAIL full_req%0d: got %b want 1", b, BURST_REQ); end
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
        cyc(0, 0, 0, 0);
        exp = 16'h2000 + 16'(b * 8 + i);
        n_checks++;
        if (DATAIN !== exp || DM !== 2'b00 || BURST_ACTIVE !== 1'b1) begin
          n_fail++;
          $display("FAIL full_b%0d_beat%0d: got %h/%b/%b want %h/00/1", b, i, DATAIN, DM, BURST_ACTIVE, exp);
        end
      end
    end
    n_checks++;
    if (WR_COUNT !== 5'd0 || WR_FULL !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: count %0d full %b want 0/0", WR_COUNT, WR_FULL);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) cyc(1, 16'h3000 + 16'(i), 2'b00, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h3100 + 16'(i), 2'b00, 0);
      exp = 16'h3000 + 16'(i);
      n_checks++;
      if (DATAIN !== exp || BURST_ACTIVE !== 1'b1 || WR_COUNT !== 5'd8) begin
        n_fail++;
        $display("FAIL b2b_first%0d: got %h/%b/%0d want %h/1/8", i, DATAIN, BURST_ACTIVE, WR_COUNT, exp);
      end
    end
    n_checks++;
    if (BURST_REQ !== 1'b1) begin n_fail++; $display("FAIL b2b_req: got %b want 1", BURST_REQ); end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (BURST_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: active %b want 0", BURST_ACTIVE); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      exp = 16'h3100 + 16'(i);
      n_checks++;
      if (DATAIN !== exp || BURST_ACTIVE !== 1'b1) begin
        n_fail++; $display("FAIL b2b_second%0d: got %h/%b want %h/1", i, DATAIN, BURST_ACTIVE, exp);
      end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_ignored_start();
    logic [15:0] exp;
    for (int i = 0; i < 7; i++) cyc(1, 16'h4000 + 16'(i), 2'b00, 0);
    n_checks++;
    if (BURST_REQ !== 1'b0) begin n_fail++; $display("FAIL ign_req7: got %b want 0", BURST_REQ); end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    n_checks++;
    if (BURST_ACTIVE !== 1'b0 || WR_COUNT !== 5'd7 || DM !== 2'b11) begin
      n_fail++; $display("FAIL ign_short: active %b count %0d dm %b want 0/7/11", BURST_ACTIVE, WR_COUNT, DM);
    end
    cyc(1, 16'h4007, 2'b00, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, i == 2);
      exp = 16'h4000 + 16'(i);
      n_checks++;
      if (DATAIN !== exp || BURST_ACTIVE !== 1'b1) begin
        n_fail++; $display("FAIL ign_beat%0d: got %h/%b want %h/1", i, DATAIN, BURST_ACTIVE, exp);
      end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (BURST_ACTIVE !== 1'b0 || WR_COUNT !== 5'd0 || BURST_REQ !== 1'b0) begin
      n_fail++; $display("FAIL ign_end: active %b count %0d req %b want 0/0/0", BURST_ACTIVE, WR_COUNT, BURST_REQ);
    end
  endtask

  task automatic test_dm_mask();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) cyc(1, 16'h5000 + 16'(i), (i == 3) ? 2'b10 : 2'b00, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      exp = (i == 3) ? 2'b10 : 2'b00;
      n_checks++;
      if (DM !== exp) begin n_fail++; $display("FAIL dm_beat%0d: got %b want %b", i, DM, exp); end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 12; i++) cyc(1, 16'h6000 + 16'(i), 2'b00, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    n_checks++;
    if (DATAIN !== 16'h6003 || BURST_ACTIVE !== 1'b1) begin
      n_fail++; $display("FAIL rst_beat4: got %h/%b want 6003/1", DATAIN, BURST_ACTIVE);
    end
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (DM !== 2'b11 || BURST_ACTIVE !== 1'b0 || WR_COUNT !== 5'd0 || DATAIN !== 16'h0) begin
      n_fail++; $display("FAIL rst_abort: dm %b active %b count %0d data %h want 11/0/0/0000",
                         DM, BURST_ACTIVE, WR_COUNT, DATAIN);
    end
    model_clear();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (BURST_ACTIVE !== 1'b0 || WR_COUNT !== 5'd0 || BURST_REQ !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: active %b count %0d req %b want 0/0/0", BURST_ACTIVE, WR_COUNT, BURST_REQ);
    end
  endtask

  task automatic test_random();
    logic [15:0] e_data;
    logic [1:0]  e_dm;
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 9) < 7), 16'($urandom), 2'($urandom), ($urandom_range(0, 9) < 3));
      e_data = m_valid ? m_word[15:0] : 16'h0000;
      e_dm   = m_valid ? m_word[17:16] : 2'b11;
      n_checks++;
      if (WR_COUNT !== 5'(mq.size()) || WR_FULL !== (mq.size() == DEPTH) ||
          BURST_REQ !== ((m_busy == 0) && (mq.size() >= BL)) || BURST_ACTIVE !== m_valid ||
          DATAIN !== e_data || DM !== e_dm) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: cnt %0d full %b req %b act %b data %h dm %b want %0d/%b/%b/%b/%h/%b",
                 c, WR_COUNT, WR_FULL, BURST_REQ, BURST_ACTIVE, DATAIN, DM, mq.size(),
                 (mq.size() == DEPTH), ((m_busy == 0) && (mq.size() >= BL)), m_valid, e_data, e_dm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_full();
    test_back_to_back();
    test_ignored_start();
    test_dm_mask();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
